// File: rtl/aes_block_loader.sv
// Word-stream front end for the AES round controller: stages key/plaintext pairs into two
// ping-pong slots and holds the controller start level for exactly one encryption per slot.
module aes_block_loader #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   output logic             start_o,
   input  logic             accept_i,
   input  logic             done_i,
   output logic [127:0]     key_o,
   output logic [127:0]     pt_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] blk_cnt_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0][127:0] key_q, key_d;
   logic [1:0][127:0] pt_q, pt_d;
   logic [1:0]        slot_full_q, slot_full_d;
   logic              wr_slot_q, wr_slot_d;
   logic              rd_slot_q, rd_slot_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic              xfer;
   logic              last_word;

   // Ready looks only at registered occupancy, so a slot released this cycle refills from the next.
   assign s_ready   = ~slot_full_q[wr_slot_q];
   assign xfer      = s_valid & s_ready;
   assign last_word = xfer & (wcnt_q == 3'd7);

   assign key_o     = key_q[rd_slot_q];
   assign pt_o      = pt_q[rd_slot_q];
   assign blk_cnt_o = blk_cnt_q;

   always_comb begin
      key_d     = key_q;
      pt_d      = pt_q;
      wcnt_d    = wcnt_q;
      wr_slot_d = wr_slot_q;
      if (xfer) begin
         case (wcnt_q)
            3'd0:    key_d[wr_slot_q][127:96] = s_data;
            3'd1:    key_d[wr_slot_q][95:64]  = s_data;
            3'd2:    key_d[wr_slot_q][63:32]  = s_data;
            3'd3:    key_d[wr_slot_q][31:0]   = s_data;
            3'd4:    pt_d[wr_slot_q][127:96]  = s_data;
            3'd5:    pt_d[wr_slot_q][95:64]   = s_data;
            3'd6:    pt_d[wr_slot_q][63:32]   = s_data;
            default: pt_d[wr_slot_q][31:0]    = s_data;
         endcase
         wcnt_d = wcnt_q + 3'd1;
         if (last_word) begin
            wr_slot_d = ~wr_slot_q;
         end
      end
   end

   // Fill (set) and release (clear) never touch the same slot: a slot being written is never full.
   always_comb begin
      state_d     = state_q;
      slot_full_d = slot_full_q;
      rd_slot_d   = rd_slot_q;
      blk_cnt_d   = blk_cnt_q;
      start_o     = 1'b0;
      busy_o      = 1'b0;
      if (last_word) begin
         slot_full_d[wr_slot_q] = 1'b1;
      end
      case (state_q)
         IDLE: begin
            start_o = slot_full_q[rd_slot_q] & accept_i;
            if (start_o) begin
               state_d = RUN;
            end
         end
         RUN: begin
            busy_o  = 1'b1;
            start_o = ~done_i;
            if (done_i) begin
               slot_full_d[rd_slot_q] = 1'b0;
               rd_slot_d              = ~rd_slot_q;
               blk_cnt_d              = blk_cnt_q + CNT_W'(1);
               state_d                = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         key_q       <= '0;
         pt_q        <= '0;
         slot_full_q <= 2'b00;
         wr_slot_q   <= 1'b0;
         rd_slot_q   <= 1'b0;
         wcnt_q      <= 3'd0;
         blk_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         pt_q        <= pt_d;
         slot_full_q <= slot_full_d;
         wr_slot_q   <= wr_slot_d;
         rd_slot_q   <= rd_slot_d;
         wcnt_q      <= wcnt_d;
         blk_cnt_q   <= blk_cnt_d;
      end
   end

endmodule
